// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4 encodings and engine state types for the BRAM slave.
//   BURST_*  : AxBURST encodings (FIXED/INCR/WRAP; 2'b11 is reserved)
//   RESP_*   : xRESP encodings
//   wr_state_e / rd_state_e : write and read engine states
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for a 32-bit-wide AXI burst.
//   addr_i      : current beat byte address
//   len_i       : AxLEN (beats-1)
//   burst_i     : AxBURST
//   next_addr_o : address of the following beat
//   bad_burst_o : reserved burst type, or WRAP with an illegal length (both advance as INCR)
module axi_burst_addr_gen import axi_pkg::*; (
  input  logic [31:0] addr_i,
  input  logic [7:0]  len_i,
  input  logic [1:0]  burst_i,
  output logic [31:0] next_addr_o,
  output logic        bad_burst_o
);

  logic        wrap_len_ok;
  logic [31:0] incr;
  logic [31:0] mask;

  assign wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
  assign incr        = addr_i + 32'd4;
  // Window is (LEN+1)*4 bytes; for legal wrap lengths that minus one is {LEN,2'b11}.
  assign mask        = {22'd0, len_i, 2'b11};

  always_comb begin
    next_addr_o = incr;
    bad_burst_o = 1'b0;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr;
      BURST_WRAP: begin
        if (wrap_len_ok) next_addr_o = (addr_i & ~mask) | (incr & mask);
        else             bad_burst_o = 1'b1;
      end
      default:     bad_burst_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_bram_slave.sv
// axi_bram_slave: AXI4 slave backed by a 2**MEM_AW x 32 word memory.
//   Write engine (AW/W/B) and read engine (AR/R) run independently, one burst each.
//   BUS_CLK/BUS_RSTN : clock, synchronous active-low reset
//   S_WR_ADDR_* / S_WR_DATA* / S_WR_BACK_* : AW, W and B channels
//   S_RD_ADDR_* / S_RD_* : AR and R channels
// Out-of-range beats drop writes / return zero and make the response SLVERR.
module axi_bram_slave import axi_pkg::*; #(
  parameter int          S_ID      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_AW    = 10
)(
  input  logic            BUS_CLK,
  input  logic            BUS_RSTN,
  input  logic [S_ID-1:0] S_WR_ADDR_ID,
  input  logic [31:0]     S_WR_ADDR,
  input  logic [7:0]      S_WR_ADDR_LEN,
  input  logic [1:0]      S_WR_ADDR_BURST,
  input  logic            S_WR_ADDR_VALID,
  output logic            S_WR_ADDR_READY,
  input  logic [31:0]     S_WR_DATA,
  input  logic [3:0]      S_WR_STRB,
  input  logic            S_WR_DATA_LAST,
  input  logic            S_WR_DATA_VALID,
  output logic            S_WR_DATA_READY,
  output logic [S_ID-1:0] S_WR_BACK_ID,
  output logic [1:0]      S_WR_BACK_RESP,
  output logic            S_WR_BACK_VALID,
  input  logic            S_WR_BACK_READY,
  input  logic [S_ID-1:0] S_RD_ADDR_ID,
  input  logic [31:0]     S_RD_ADDR,
  input  logic [7:0]      S_RD_ADDR_LEN,
  input  logic [1:0]      S_RD_ADDR_BURST,
  input  logic            S_RD_ADDR_VALID,
  output logic            S_RD_ADDR_READY,
  output logic [S_ID-1:0] S_RD_BACK_ID,
  output logic [31:0]     S_RD_DATA,
  output logic [1:0]      S_RD_DATA_RESP,
  output logic            S_RD_DATA_LAST,
  output logic            S_RD_DATA_VALID,
  input  logic            S_RD_DATA_READY
);

  localparam int DEPTH = 2**MEM_AW;

  logic [31:0] mem [DEPTH];

  function automatic logic addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> (MEM_AW + 2)) == 32'd0);
  endfunction

  function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[MEM_AW+1:2];
  endfunction

  // ---------------- write engine ----------------
  wr_state_e       wst_q, wst_d;
  logic [S_ID-1:0] wid_q, wid_d;
  logic [31:0]     waddr_q, waddr_d, w_next;
  logic [7:0]      wlen_q, wlen_d;
  logic [1:0]      wburst_q, wburst_d, wresp_q, wresp_d;
  logic [8:0]      wcnt_q, wcnt_d;   // one extra bit so beats past LEN are recognisable
  logic            w_bad, wr_en;

  axi_burst_addr_gen u_wr_gen (
    .addr_i(waddr_q), .len_i(wlen_q), .burst_i(wburst_q),
    .next_addr_o(w_next), .bad_burst_o(w_bad)
  );

  always_comb begin
    wst_d = wst_q; wid_d = wid_q; waddr_d = waddr_q; wlen_d = wlen_q;
    wburst_d = wburst_q; wresp_d = wresp_q; wcnt_d = wcnt_q;
    wr_en = 1'b0;
    case (wst_q)
      W_IDLE: if (S_WR_ADDR_VALID) begin
        wid_d = S_WR_ADDR_ID; waddr_d = S_WR_ADDR; wlen_d = S_WR_ADDR_LEN;
        wburst_d = S_WR_ADDR_BURST; wcnt_d = '0; wresp_d = RESP_OKAY;
        wst_d = W_DATA;
      end
      W_DATA: if (S_WR_DATA_VALID) begin
        if (wcnt_q <= {1'b0, wlen_q}) begin
          // A reset edge abandons the burst, so it must not land a beat either.
          wr_en = addr_ok(waddr_q) && BUS_RSTN;
          if (!addr_ok(waddr_q) || w_bad) wresp_d = RESP_SLVERR;
          // LAST must coincide exactly with beat LEN.
          if (S_WR_DATA_LAST != (wcnt_q == {1'b0, wlen_q})) wresp_d = RESP_SLVERR;
          waddr_d = w_next;
          wcnt_d  = wcnt_q + 9'd1;
        end
        if (S_WR_DATA_LAST) wst_d = W_RESP;
      end
      W_RESP: if (S_WR_BACK_READY) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RSTN) begin
      wst_q <= W_IDLE; wid_q <= '0; waddr_q <= '0; wlen_q <= '0;
      wburst_q <= '0; wresp_q <= RESP_OKAY; wcnt_q <= '0;
    end else begin
      wst_q <= wst_d; wid_q <= wid_d; waddr_q <= waddr_d; wlen_q <= wlen_d;
      wburst_q <= wburst_d; wresp_q <= wresp_d; wcnt_q <= wcnt_d;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (S_WR_STRB[b]) mem[word_idx(waddr_q)][8*b +: 8] <= S_WR_DATA[8*b +: 8];
  end

  assign S_WR_ADDR_READY = (wst_q == W_IDLE);
  assign S_WR_DATA_READY = (wst_q == W_DATA);
  assign S_WR_BACK_VALID = (wst_q == W_RESP);
  assign S_WR_BACK_ID    = wid_q;
  assign S_WR_BACK_RESP  = wresp_q;

  // ---------------- read engine ----------------
  rd_state_e       rst_q, rst_d;
  logic [S_ID-1:0] rid_q, rid_d;
  logic [31:0]     raddr_q, raddr_d, r_next, rdata_q;
  logic [7:0]      rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [1:0]      rburst_q, rburst_d, rresp_q, rresp_d;
  logic            rvalid_q, rvalid_d, rlast_q, rlast_d, r_bad, rd_load;

  axi_burst_addr_gen u_rd_gen (
    .addr_i(raddr_q), .len_i(rlen_q), .burst_i(rburst_q),
    .next_addr_o(r_next), .bad_burst_o(r_bad)
  );

  // The memory read register is the R data register: a beat is loaded whenever
  // the output slot is empty or being consumed, so stalled beats stay put.
  always_comb begin
    rst_d = rst_q; rid_d = rid_q; raddr_d = raddr_q; rlen_d = rlen_q;
    rburst_d = rburst_q; rresp_d = rresp_q; rcnt_d = rcnt_q;
    rvalid_d = rvalid_q; rlast_d = rlast_q;
    rd_load = 1'b0;
    case (rst_q)
      R_IDLE: if (S_RD_ADDR_VALID) begin
        rid_d = S_RD_ADDR_ID; raddr_d = S_RD_ADDR; rlen_d = S_RD_ADDR_LEN;
        rburst_d = S_RD_ADDR_BURST; rcnt_d = '0; rlast_d = 1'b0;
        rst_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid_q && S_RD_DATA_READY && rlast_q) begin
          rvalid_d = 1'b0; rlast_d = 1'b0; rst_d = R_IDLE;
        end else if ((!rvalid_q || S_RD_DATA_READY) && !rlast_q) begin
          rd_load  = 1'b1;
          rvalid_d = 1'b1;
          rlast_d  = (rcnt_q == rlen_q);
          rresp_d  = (addr_ok(raddr_q) && !r_bad) ? RESP_OKAY : RESP_SLVERR;
          raddr_d  = r_next;
          rcnt_d   = rcnt_q + 8'd1;
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RSTN) begin
      rst_q <= R_IDLE; rid_q <= '0; raddr_q <= '0; rlen_q <= '0; rburst_q <= '0;
      rresp_q <= RESP_OKAY; rcnt_q <= '0; rvalid_q <= 1'b0; rlast_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      rst_q <= rst_d; rid_q <= rid_d; raddr_q <= raddr_d; rlen_q <= rlen_d;
      rburst_q <= rburst_d; rresp_q <= rresp_d; rcnt_q <= rcnt_d;
      rvalid_q <= rvalid_d; rlast_q <= rlast_d;
      if (rd_load) rdata_q <= addr_ok(raddr_q) ? mem[word_idx(raddr_q)] : 32'd0;
    end
  end

  assign S_RD_ADDR_READY = (rst_q == R_IDLE);
  assign S_RD_BACK_ID    = rid_q;
  assign S_RD_DATA       = rdata_q;
  assign S_RD_DATA_RESP  = rresp_q;
  assign S_RD_DATA_LAST  = rlast_q;
  assign S_RD_DATA_VALID = rvalid_q;

endmodule

// File: tb/tb_axi_bram_slave.sv
// tb_axi_bram_slave: directed, table-driven and random AXI traffic against a
// word-array memory model built from the burst/range rules.
module tb_axi_bram_slave;

  localparam int DEPTH  = 1024;
  localparam int BUDGET = 600;

  logic        BUS_CLK = 1'b0, BUS_RSTN = 1'b0;
  logic [3:0]  S_WR_ADDR_ID = '0, S_RD_ADDR_ID = '0, S_WR_BACK_ID, S_RD_BACK_ID;
  logic [31:0] S_WR_ADDR = '0, S_RD_ADDR = '0, S_WR_DATA = '0, S_RD_DATA;
  logic [7:0]  S_WR_ADDR_LEN = '0, S_RD_ADDR_LEN = '0;
  logic [1:0]  S_WR_ADDR_BURST = '0, S_RD_ADDR_BURST = '0, S_WR_BACK_RESP, S_RD_DATA_RESP;
  logic [3:0]  S_WR_STRB = '0;
  logic        S_WR_ADDR_VALID = 0, S_WR_DATA_LAST = 0, S_WR_DATA_VALID = 0, S_WR_BACK_READY = 0;
  logic        S_RD_ADDR_VALID = 0, S_RD_DATA_READY = 0;
  logic        S_WR_ADDR_READY, S_WR_DATA_READY, S_WR_BACK_VALID;
  logic        S_RD_ADDR_READY, S_RD_DATA_LAST, S_RD_DATA_VALID;

  always #5 BUS_CLK = ~BUS_CLK;

  axi_bram_slave #(.S_ID(4), .BASE_ADDR(32'h0), .MEM_AW(10)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RSTN(BUS_RSTN),
    .S_WR_ADDR_ID(S_WR_ADDR_ID), .S_WR_ADDR(S_WR_ADDR), .S_WR_ADDR_LEN(S_WR_ADDR_LEN),
    .S_WR_ADDR_BURST(S_WR_ADDR_BURST), .S_WR_ADDR_VALID(S_WR_ADDR_VALID),
    .S_WR_ADDR_READY(S_WR_ADDR_READY), .S_WR_DATA(S_WR_DATA), .S_WR_STRB(S_WR_STRB),
    .S_WR_DATA_LAST(S_WR_DATA_LAST), .S_WR_DATA_VALID(S_WR_DATA_VALID),
    .S_WR_DATA_READY(S_WR_DATA_READY), .S_WR_BACK_ID(S_WR_BACK_ID),
    .S_WR_BACK_RESP(S_WR_BACK_RESP), .S_WR_BACK_VALID(S_WR_BACK_VALID),
    .S_WR_BACK_READY(S_WR_BACK_READY), .S_RD_ADDR_ID(S_RD_ADDR_ID), .S_RD_ADDR(S_RD_ADDR),
    .S_RD_ADDR_LEN(S_RD_ADDR_LEN), .S_RD_ADDR_BURST(S_RD_ADDR_BURST),
    .S_RD_ADDR_VALID(S_RD_ADDR_VALID), .S_RD_ADDR_READY(S_RD_ADDR_READY),
    .S_RD_BACK_ID(S_RD_BACK_ID), .S_RD_DATA(S_RD_DATA), .S_RD_DATA_RESP(S_RD_DATA_RESP),
    .S_RD_DATA_LAST(S_RD_DATA_LAST), .S_RD_DATA_VALID(S_RD_DATA_VALID),
    .S_RD_DATA_READY(S_RD_DATA_READY)
  );

  int n_chk = 0, n_fail = 0;
  logic [31:0] model [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit bad_burst(input logic [7:0] len, input logic [1:0] burst);
    return (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [1:0] burst, input int i);
    logic [31:0] size;
    if (burst == 2'b00) return a;
    if (burst == 2'b10 && !bad_burst(len, burst)) begin
      size = 32'((int'(len) + 1) * 4);
      return a - (a % size) + (((a % size) + 32'(4 * i)) % size);
    end
    return a + 32'(4 * i);
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'(DEPTH * 4);
  endfunction

  function automatic logic [1:0] model_wr(input logic [31:0] addr, input logic [7:0] len,
      input logic [1:0] burst, input logic [31:0] dq[$], input logic [3:0] sq[$], input int lastidx);
    logic [1:0] r;
    logic [31:0] a;
    r = (bad_burst(len, burst) || lastidx != int'(len)) ? 2'b10 : 2'b00;
    for (int i = 0; i <= lastidx && i <= int'(len); i++) begin
      a = beat_addr(addr, len, burst, i);
      if (!in_rng(a)) r = 2'b10;
      else for (int b = 0; b < 4; b++)
        if (sq[i][b]) model[a[11:2]][8*b +: 8] = dq[i][8*b +: 8];
    end
    return r;
  endfunction

  // ---------------- bus master tasks ----------------
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
      input logic [1:0] burst, input logic [31:0] dq[$], input logic [3:0] sq[$], input int lastidx,
      output logic [3:0] bid, output logic [1:0] bresp);
    int t;
    @(negedge BUS_CLK);
    S_WR_ADDR_ID = id; S_WR_ADDR = addr; S_WR_ADDR_LEN = len; S_WR_ADDR_BURST = burst;
    S_WR_ADDR_VALID = 1;
    t = 0; while (!S_WR_ADDR_READY && t < BUDGET) begin @(negedge BUS_CLK); t++; end
    if (t >= BUDGET) chk("aw_timeout", 0, 1);
    @(negedge BUS_CLK);
    S_WR_ADDR_VALID = 0;
    for (int k = 0; k <= lastidx; k++) begin
      S_WR_DATA = dq[k]; S_WR_STRB = sq[k]; S_WR_DATA_LAST = (k == lastidx); S_WR_DATA_VALID = 1;
      t = 0; while (!S_WR_DATA_READY && t < BUDGET) begin @(negedge BUS_CLK); t++; end
      if (t >= BUDGET) chk("w_timeout", 0, 1);
      @(negedge BUS_CLK);
    end
    S_WR_DATA_VALID = 0; S_WR_DATA_LAST = 0;
    t = 0; while (!S_WR_BACK_VALID && t < BUDGET) begin @(negedge BUS_CLK); t++; end
    if (t >= BUDGET) chk("b_timeout", 0, 1);
    bid = S_WR_BACK_ID; bresp = S_WR_BACK_RESP;
    S_WR_BACK_READY = 1;
    @(negedge BUS_CLK);
    S_WR_BACK_READY = 0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
      input logic [1:0] burst, input bit toggle,
      output logic [31:0] dq[$], output logic [1:0] rq[$], output bit lq[$], output logic [3:0] iq[$],
      output int first_lat, output int stall_bad);
    int t, c;
    bit held, done;
    logic [31:0] hd;
    dq = {}; rq = {}; lq = {}; iq = {};
    first_lat = -1; stall_bad = 0; held = 0; done = 0; hd = '0;
    @(negedge BUS_CLK);
    S_RD_ADDR_ID = id; S_RD_ADDR = addr; S_RD_ADDR_LEN = len; S_RD_ADDR_BURST = burst;
    S_RD_ADDR_VALID = 1;
    t = 0; while (!S_RD_ADDR_READY && t < BUDGET) begin @(negedge BUS_CLK); t++; end
    if (t >= BUDGET) chk("ar_timeout", 0, 1);
    @(negedge BUS_CLK);
    S_RD_ADDR_VALID = 0;
    c = 1;   // cycle count after the AR handshake edge
    while (!done && c < BUDGET) begin
      S_RD_DATA_READY = toggle ? (c % 2 == 1) : 1'b1;
      if (S_RD_DATA_VALID) begin
        if (first_lat < 0) first_lat = c;
        if (held && S_RD_DATA !== hd) stall_bad++;
        held = 0;
        if (S_RD_DATA_READY) begin
          dq.push_back(S_RD_DATA); rq.push_back(S_RD_DATA_RESP);
          lq.push_back(S_RD_DATA_LAST); iq.push_back(S_RD_BACK_ID);
          if (S_RD_DATA_LAST) done = 1;
        end else begin
          held = 1; hd = S_RD_DATA;
        end
      end
      @(negedge BUS_CLK); c++;
    end
    S_RD_DATA_READY = 0;
    if (!done) chk("r_timeout", 0, 1);
  endtask

  task automatic check_write(input string nm, input logic [3:0] id, input logic [31:0] addr,
      input logic [7:0] len, input logic [1:0] burst, input logic [31:0] dq[$], input logic [3:0] sq[$],
      input int lastidx, output logic [1:0] resp);
    logic [3:0] bid;
    logic [1:0] er;
    axi_write(id, addr, len, burst, dq, sq, lastidx, bid, resp);
    er = model_wr(addr, len, burst, dq, sq, lastidx);
    chk({nm, "_bresp"}, 32'(resp), 32'(er));
    chk({nm, "_bid"}, 32'(bid), 32'(id));
  endtask

  task automatic check_read(input string nm, input logic [3:0] id, input logic [31:0] addr,
      input logic [7:0] len, input logic [1:0] burst, input bit toggle, output logic [1:0] worst);
    logic [31:0] dq[$];
    logic [1:0] rq[$];
    bit lq[$];
    logic [3:0] iq[$];
    int fl, sb;
    logic [31:0] a;
    axi_read(id, addr, len, burst, toggle, dq, rq, lq, iq, fl, sb);
    chk({nm, "_beats"}, 32'(dq.size()), 32'(int'(len) + 1));
    chk({nm, "_latency"}, 32'(fl), 32'd2);
    chk({nm, "_stall"}, 32'(sb), 32'd0);
    worst = 2'b00;
    for (int i = 0; i < dq.size() && i <= int'(len); i++) begin
      a = beat_addr(addr, len, burst, i);
      chk($sformatf("%s_data[%0d]", nm, i), dq[i], in_rng(a) ? model[a[11:2]] : 32'd0);
      chk($sformatf("%s_resp[%0d]", nm, i), 32'(rq[i]),
          (in_rng(a) && !bad_burst(len, burst)) ? 32'd0 : 32'd2);
      chk($sformatf("%s_last[%0d]", nm, i), 32'(lq[i]), 32'(i == int'(len)));
      chk($sformatf("%s_id[%0d]", nm, i), 32'(iq[i]), 32'(id));
      worst |= rq[i];
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_awready"}, 32'(S_WR_ADDR_READY), 1);
    chk({tag, "_arready"}, 32'(S_RD_ADDR_READY), 1);
    chk({tag, "_wready"},  32'(S_WR_DATA_READY), 0);
    chk({tag, "_bvalid"},  32'(S_WR_BACK_VALID), 0);
    chk({tag, "_bresp"},   32'(S_WR_BACK_RESP), 0);
    chk({tag, "_bid"},     32'(S_WR_BACK_ID), 0);
    chk({tag, "_rvalid"},  32'(S_RD_DATA_VALID), 0);
    chk({tag, "_rlast"},   32'(S_RD_DATA_LAST), 0);
    chk({tag, "_rresp"},   32'(S_RD_DATA_RESP), 0);
    chk({tag, "_rid"},     32'(S_RD_BACK_ID), 0);
    chk({tag, "_rdata"},   S_RD_DATA, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    int          lastidx;
    logic [1:0]  exp_resp;   // B resp for writes, worst beat resp for reads
  } vec_t;

  initial begin
    vec_t        vecs[12];
    logic [31:0] dq[$], rd[$];
    logic [3:0]  sq[$], iq[$];
    logic [1:0]  rq[$], resp;
    bit          lq[$];
    int          fl, sb, li;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] addr;

    // reset state
    repeat (3) @(negedge BUS_CLK);
    chk_reset("reset");
    BUS_RSTN = 1;

    // known background: word i = C0DE0000 | i
    for (int blk = 0; blk < 4; blk++) begin
      dq = {}; sq = {};
      for (int i = 0; i < 256; i++) begin dq.push_back(32'hC0DE0000 | 32'(blk * 256 + i)); sq.push_back(4'hF); end
      check_write($sformatf("fill%0d", blk), 4'h0, 32'(blk * 1024), 8'd255, 2'b01, dq, sq, 255, resp);
    end

    // INCR write then read back
    dq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3}; sq = '{4'hF, 4'hF, 4'hF, 4'hF};
    check_write("incr_wr", 4'h5, 32'h10, 8'd3, 2'b01, dq, sq, 3, resp);
    chk("incr_wr_okay", 32'(resp), 0);
    check_read("incr_rd", 4'h9, 32'h10, 8'd3, 2'b01, 0, resp);

    // WRAP read from 0x38: words 14,15,12,13
    axi_read(4'hA, 32'h38, 8'd3, 2'b10, 0, rd, rq, lq, iq, fl, sb);
    chk("wrap_b0", rd[0], 32'hC0DE000E);
    chk("wrap_b1", rd[1], 32'hC0DE000F);
    chk("wrap_b2", rd[2], 32'hC0DE000C);
    chk("wrap_b3", rd[3], 32'hC0DE000D);
    chk("wrap_last3", 32'(lq[3]), 1);
    chk("wrap_last2", 32'(lq[2]), 0);
    chk("wrap_lat", 32'(fl), 2);

    // byte strobes
    dq = '{32'hFFFFFFFF}; sq = '{4'hF};
    check_write("strb_a", 4'h1, 32'h0, 8'd0, 2'b01, dq, sq, 0, resp);
    dq = '{32'h12345678}; sq = '{4'b0101};
    check_write("strb_b", 4'h2, 32'h0, 8'd0, 2'b01, dq, sq, 0, resp);
    axi_read(4'h3, 32'h0, 8'd0, 2'b01, 0, rd, rq, lq, iq, fl, sb);
    chk("strb_rd", rd[0], 32'hFF34FF78);

    // R backpressure 1010 over 8 beats
    check_read("bp_rd", 4'h6, 32'h40, 8'd7, 2'b01, 1, resp);

    // out-of-range write, early LAST
    dq = '{32'hDEADBEEF}; sq = '{4'hF};
    check_write("oor_wr", 4'h7, 32'(DEPTH * 4), 8'd0, 2'b01, dq, sq, 0, resp);
    chk("oor_wr_slverr", 32'(resp), 2);
    axi_read(4'h3, 32'h0, 8'd0, 2'b01, 0, rd, rq, lq, iq, fl, sb);
    chk("oor_untouched", rd[0], 32'hFF34FF78);
    dq = '{32'h11, 32'h22}; sq = '{4'hF, 4'hF};
    check_write("early_last", 4'h8, 32'h100, 8'd3, 2'b01, dq, sq, 1, resp);
    chk("early_last_slverr", 32'(resp), 2);
    check_read("early_last_rd", 4'h8, 32'h100, 8'd3, 2'b01, 0, resp);

    // table of burst-type / range corner cases
    vecs[0]  = '{1, 4'h1, 32'h200, 8'd3, 2'b00, 3, 2'b00};   // FIXED write
    vecs[1]  = '{0, 4'h2, 32'h200, 8'd2, 2'b00, 0, 2'b00};   // FIXED read
    vecs[2]  = '{1, 4'h3, 32'h300, 8'd2, 2'b10, 2, 2'b10};   // WRAP illegal len
    vecs[3]  = '{1, 4'h4, 32'h320, 8'd1, 2'b11, 1, 2'b10};   // reserved burst
    vecs[4]  = '{0, 4'h5, 32'h300, 8'd1, 2'b11, 0, 2'b10};   // reserved burst read
    vecs[5]  = '{1, 4'h6, 32'hFF8, 8'd3, 2'b01, 3, 2'b10};   // runs off the top
    vecs[6]  = '{0, 4'h7, 32'hFF8, 8'd3, 2'b01, 0, 2'b10};
    vecs[7]  = '{1, 4'h8, 32'h340, 8'd1, 2'b01, 3, 2'b10};   // LAST missing, extra beats
    vecs[8]  = '{0, 4'h9, 32'h3C4, 8'd7, 2'b10, 0, 2'b00};   // WRAP 8
    vecs[9]  = '{1, 4'hA, 32'h404, 8'd15, 2'b10, 15, 2'b00}; // WRAP 16
    vecs[10] = '{0, 4'hB, 32'hFFFFFFFC, 8'd1, 2'b01, 0, 2'b10}; // 32-bit wrap to 0
    vecs[11] = '{0, 4'hC, 32'h343, 8'd3, 2'b01, 0, 2'b00};   // unaligned addr
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].wr) begin
        dq = {}; sq = {};
        for (int i = 0; i <= vecs[v].lastidx; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
        check_write($sformatf("vec%0d", v), vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst,
                    dq, sq, vecs[v].lastidx, resp);
      end else
        check_read($sformatf("vec%0d", v), vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst, 0, resp);
      chk($sformatf("vec%0d_resp", v), 32'(resp), 32'(vecs[v].exp_resp));
    end

    // write and read engines concurrently on disjoint regions
    dq = {}; sq = {};
    for (int i = 0; i < 8; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    fork
      check_write("conc_wr", 4'hD, 32'h800, 8'd7, 2'b01, dq, sq, 7, resp);
      check_read("conc_rd", 4'hE, 32'h600, 8'd7, 2'b01, 0, resp);
    join
    check_read("conc_chk", 4'hE, 32'h800, 8'd7, 2'b01, 0, resp);

    // random traffic against the model
    for (int n = 0; n < 40; n++) begin
      burst = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: len = 8'd1;  1: len = 8'd3;  2: len = 8'd7;
        default: len = 8'($urandom_range(0, 15));
      endcase
      addr = 32'($urandom_range(0, 1100)) * 4 + 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
      if ($urandom_range(0, 1) == 1) begin
        li = ($urandom_range(0, 4) == 0) ? $urandom_range(0, int'(len) + 1) : int'(len);
        dq = {}; sq = {};
        for (int i = 0; i <= li; i++) begin dq.push_back($urandom); sq.push_back(4'($urandom)); end
        check_write($sformatf("rnd%0d", n), 4'($urandom), addr, len, burst, dq, sq, li, resp);
      end else
        check_read($sformatf("rnd%0d", n), 4'($urandom), addr, len, burst, bit'($urandom), resp);
    end

    // reset during W_DATA beat 2
    @(negedge BUS_CLK);
    S_WR_ADDR_ID = 4'h3; S_WR_ADDR = 32'h500; S_WR_ADDR_LEN = 8'd3; S_WR_ADDR_BURST = 2'b01;
    S_WR_ADDR_VALID = 1;
    @(negedge BUS_CLK);
    S_WR_ADDR_VALID = 0;
    dq = {}; sq = {};
    for (int k = 0; k < 2; k++) begin
      S_WR_DATA = 32'h5A5A0000 + 32'(k); S_WR_STRB = 4'hF; S_WR_DATA_VALID = 1;
      dq.push_back(S_WR_DATA); sq.push_back(4'hF);
      chk($sformatf("mid_wready%0d", k), 32'(S_WR_DATA_READY), 1);
      @(negedge BUS_CLK);
    end
    S_WR_DATA_VALID = 0;
    BUS_RSTN = 0;
    @(negedge BUS_CLK);
    chk_reset("mid_reset");
    BUS_RSTN = 1;
    resp = model_wr(32'h500, 8'd1, 2'b01, dq, sq, 1);   // beats 0,1 landed before the reset
    dq = '{32'h77, 32'h88}; sq = '{4'hF, 4'hF};
    check_write("post_reset_wr", 4'h4, 32'h508, 8'd1, 2'b01, dq, sq, 1, resp);
    chk("post_reset_okay", 32'(resp), 0);
    check_read("post_reset_rd", 4'h4, 32'h500, 8'd3, 2'b01, 0, resp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
